// File: rtl/icache_pkg.sv
// Shared types and bus constants for the N-way instruction cache.
// Imported by the cache top and its PLRU sub-module.
package icache_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARB,
        S_REQ,
        S_WAIT,
        S_FILL,
        S_INSTALL
    } state_t;

    localparam logic [3:0] SYSBUS_READ   = 4'b1101;
    localparam logic [3:0] SYSBUS_MEMORY = 4'b0001;

    function automatic logic [15:0] read_req_tag();
        return {SYSBUS_MEMORY, SYSBUS_READ, 8'h00};
    endfunction

endpackage

// File: rtl/icache_nway_plru.sv
// Tree pseudo-LRU state, one WAYS-1 bit tree per set.
// A set bit at a node steers the victim search to the right subtree.
module plru_tree #(
    parameter int WAYS = 2,
    parameter int SETS = 512,
    localparam int WW = (WAYS > 1) ? $clog2(WAYS) : 1,
    localparam int IW = $clog2(SETS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          upd_en,
    input  logic [IW-1:0] upd_idx,
    input  logic [WW-1:0] upd_way,
    input  logic [IW-1:0] rd_idx,
    output logic [WW-1:0] victim
);
    import icache_pkg::*;

    localparam int LG = $clog2(WAYS);

    generate
        if (WAYS == 1) begin : g_one
            assign victim = '0;
        end else begin : g_tree
            logic [7:0] bits [SETS];
            logic [7:0] cur;
            logic [7:0] nxt;
            logic [3:0] node;
            logic [3:0] unode;

            always_comb begin
                cur  = bits[rd_idx];
                node = '0;
                for (int l = 0; l < LG; l++) begin
                    node = (node << 1) + 4'd1
                         + {3'd0, cur[node[2:0]]};
                end
                victim = WW'(node - 4'(WAYS - 1));
            end

            // Point every node on the path away from the touched way
            always_comb begin
                nxt   = bits[upd_idx];
                unode = '0;
                for (int l = 0; l < LG; l++) begin
                    nxt[unode[2:0]] = ~upd_way[LG-1-l];
                    unode = (unode << 1) + 4'd1
                          + {3'd0, upd_way[LG-1-l]};
                end
            end

            always_ff @(posedge clk) begin
                if (reset || clear) begin
                    for (int s = 0; s < SETS; s++) begin
                        bits[s] <= '0;
                    end
                end else if (upd_en) begin
                    bits[upd_idx] <= nxt;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/icache_nway.sv
// N-way set-associative read-only instruction cache with
// tree-PLRU replacement and single-outstanding-miss line fill.
module icache_nway #(
    parameter int WAYS           = 2,
    parameter int SETS           = 512,
    parameter int LINE_BYTES     = 64,
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [63:0]              pc,
    input  logic                     pc_valid,
    input  logic                     flush,
    output logic [31:0]              instr_reg,
    output logic                     data_ack,
    output logic                     icache_busreq,
    output logic                     icache_busidle,
    input  logic                     icache_busgrant,
    output logic                     bus_reqcyc,
    output logic [63:0]              bus_req,
    output logic [BUS_TAG_WIDTH-1:0] bus_reqtag,
    input  logic                     bus_reqack,
    input  logic                     bus_respcyc,
    input  logic [63:0]              bus_resp,
    input  logic [BUS_TAG_WIDTH-1:0] bus_resptag,
    output logic                     bus_respack
);
    import icache_pkg::*;

    localparam int OFF    = $clog2(LINE_BYTES);
    localparam int IDX    = $clog2(SETS);
    localparam int TAG    = 64 - IDX - OFF;
    localparam int BEATS  = LINE_BYTES / 8;
    localparam int BEAT_W = BUS_DATA_WIDTH;
    localparam int LINE_W = LINE_BYTES * 8;
    localparam int WW     = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int BW     = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int WDW    = $clog2(LINE_BYTES / 4);

    state_t state, state_n;

    logic [TAG-1:0]    tag_arr  [WAYS][SETS];
    logic [LINE_W-1:0] data_arr [WAYS][SETS];
    logic [SETS-1:0]   valid    [WAYS];

    logic [63:0]     miss_addr;
    logic [BW-1:0]   beat_cnt;
    logic [LINE_W-1:0] line_buf;
    logic            flush_pend;

    logic [IDX-1:0]  pc_idx;
    logic [TAG-1:0]  pc_tag;
    logic [WDW-1:0]  pc_wd;
    logic [IDX-1:0]  m_idx;
    logic [TAG-1:0]  m_tag;
    logic            hit_any;
    logic [WW-1:0]   hit_way;
    logic            hit;
    logic            miss;
    logic [WW-1:0]   plru_vic;
    logic [WW-1:0]   vic_way;
    logic            install;
    logic            drop;
    logic            beat_take;
    logic [15:0]     rtag;
    logic            unused_ok;

    assign pc_idx = pc[OFF+IDX-1:OFF];
    assign pc_tag = pc[63:OFF+IDX];
    assign pc_wd  = pc[OFF-1:2];
    assign m_idx  = miss_addr[OFF+IDX-1:OFF];
    assign m_tag  = miss_addr[63:OFF+IDX];
    assign rtag   = read_req_tag();
    assign unused_ok = ^{bus_resptag, pc[1:0]};

    always_comb begin
        hit_any = 1'b0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid[w][pc_idx] && tag_arr[w][pc_idx] == pc_tag) begin
                hit_any = 1'b1;
                hit_way = WW'(w);
            end
        end
    end

    assign hit  = (state == S_IDLE) && pc_valid && !flush && hit_any;
    assign miss = (state == S_IDLE) && pc_valid && !flush && !hit_any;

    assign data_ack  = hit;
    assign instr_reg = hit
        ? data_arr[hit_way][pc_idx][{pc_wd, 5'd0} +: 32]
        : 32'd0;

    // Lowest invalid way first; PLRU only when the set is full
    always_comb begin
        vic_way = plru_vic;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid[w][m_idx]) begin
                vic_way = WW'(w);
            end
        end
    end

    assign install   = (state == S_INSTALL);
    assign drop      = install && (flush_pend || flush);
    assign beat_take = bus_respcyc
        && (state == S_WAIT || state == S_FILL);

    assign icache_busreq  = (state == S_ARB) || (state == S_REQ)
                         || (state == S_WAIT) || (state == S_FILL);
    assign icache_busidle = (state == S_IDLE);
    assign bus_reqcyc     = (state == S_REQ);
    assign bus_req        = bus_reqcyc ? miss_addr : 64'd0;
    assign bus_reqtag     = bus_reqcyc ? rtag[BUS_TAG_WIDTH-1:0] : '0;
    assign bus_respack    = beat_take;

    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE:    if (miss) state_n = S_ARB;
            S_ARB:     if (icache_busgrant) state_n = S_REQ;
            S_REQ:     if (bus_reqack) state_n = S_WAIT;
            S_WAIT,
            S_FILL: begin
                if (bus_respcyc) begin
                    state_n = (beat_cnt == BW'(BEATS - 1))
                        ? S_INSTALL : S_FILL;
                end
            end
            S_INSTALL: state_n = S_IDLE;
            default:   state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            miss_addr  <= '0;
            beat_cnt   <= '0;
            flush_pend <= 1'b0;
            for (int w = 0; w < WAYS; w++) begin
                valid[w] <= '0;
            end
        end else begin
            state <= state_n;
            if (miss) begin
                miss_addr <= {pc[63:OFF], {OFF{1'b0}}};
            end
            if (beat_take) begin
                beat_cnt <= (beat_cnt == BW'(BEATS - 1))
                    ? '0 : beat_cnt + 1'b1;
            end
            if (flush && state != S_IDLE && state != S_INSTALL) begin
                flush_pend <= 1'b1;
            end
            if (install) begin
                flush_pend <= 1'b0;
            end
            if ((flush && state == S_IDLE) || drop) begin
                for (int w = 0; w < WAYS; w++) begin
                    valid[w] <= '0;
                end
            end else if (install) begin
                valid[vic_way][m_idx] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (beat_take) begin
            line_buf[{beat_cnt, 6'd0} +: BEAT_W] <= bus_resp;
        end
        if (install) begin
            tag_arr[vic_way][m_idx]  <= m_tag;
            data_arr[vic_way][m_idx] <= line_buf;
        end
    end

    plru_tree #(
        .WAYS (WAYS),
        .SETS (SETS)
    ) u_plru (
        .clk     (clk),
        .reset   (reset),
        .clear   ((flush && state == S_IDLE) || drop),
        .upd_en  (hit || (install && !drop)),
        .upd_idx (hit ? pc_idx : m_idx),
        .upd_way (hit ? hit_way : vic_way),
        .rd_idx  (m_idx),
        .victim  (plru_vic)
    );

endmodule

// File: tb/tb_icache_nway.sv
// Directed bench for icache_nway: hit vectors from a table plus
// hand-sequenced miss, eviction, flush and reset-mid-fill cases.
module tb_icache_nway;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [63:0] pc = '0;
    logic        pc_valid = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] instr_reg;
    logic        data_ack;
    logic        icache_busreq;
    logic        icache_busidle;
    logic        icache_busgrant = 1'b0;
    logic        bus_reqcyc;
    logic [63:0] bus_req;
    logic [12:0] bus_reqtag;
    logic        bus_reqack = 1'b0;
    logic        bus_respcyc = 1'b0;
    logic [63:0] bus_resp = '0;
    logic [12:0] bus_resptag = '0;
    logic        bus_respack;

    int passed = 0;
    int total  = 0;

    localparam logic [12:0] EXP_TAG = 13'h1D00;

    typedef struct {
        logic [63:0] addr;
        logic        hit;
        logic [31:0] instr;
    } vec_t;

    always #5 clk = ~clk;

    icache_nway dut (
        .clk             (clk),
        .reset           (reset),
        .pc              (pc),
        .pc_valid        (pc_valid),
        .flush           (flush),
        .instr_reg       (instr_reg),
        .data_ack        (data_ack),
        .icache_busreq   (icache_busreq),
        .icache_busidle  (icache_busidle),
        .icache_busgrant (icache_busgrant),
        .bus_reqcyc      (bus_reqcyc),
        .bus_req         (bus_req),
        .bus_reqtag      (bus_reqtag),
        .bus_reqack      (bus_reqack),
        .bus_respcyc     (bus_respcyc),
        .bus_resp        (bus_resp),
        .bus_resptag     (bus_resptag),
        .bus_respack     (bus_respack)
    );

    task automatic chk(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    task automatic probe(input vec_t v);
        @(negedge clk);
        pc = v.addr;
        pc_valid = 1'b1;
        #1;
        chk($sformatf("ack@%h", v.addr), 64'(data_ack), 64'(v.hit));
        chk($sformatf("instr@%h", v.addr), 64'(instr_reg),
            v.hit ? 64'(v.instr) : 64'd0);
        if (v.hit) chk($sformatf("nobus@%h", v.addr),
                       64'(icache_busreq), 64'd0);
        else pc_valid = 1'b0;
        @(posedge clk);
        #1 pc_valid = 1'b0;
    endtask

    task automatic run_miss(input logic [63:0] addr,
                            input logic [31:0] seed,
                            input int flush_beat,
                            input int stop_beat);
        logic [63:0] base;
        base = addr & ~64'h3F;
        @(negedge clk);
        pc = addr;
        pc_valid = 1'b1;
        #1 chk($sformatf("missack@%h", addr), 64'(data_ack), 64'd0);
        @(posedge clk);
        #1 pc_valid = 1'b0;
        @(negedge clk);
        chk("arb_busreq", 64'(icache_busreq), 64'd1);
        chk("arb_busidle", 64'(icache_busidle), 64'd0);
        chk("arb_reqcyc", 64'(bus_reqcyc), 64'd0);
        icache_busgrant = 1'b1;
        @(posedge clk);
        #1 icache_busgrant = 1'b0;
        @(negedge clk);
        chk("req_reqcyc", 64'(bus_reqcyc), 64'd1);
        chk($sformatf("req_addr@%h", addr), bus_req, base);
        chk("req_tag", 64'(bus_reqtag), 64'(EXP_TAG));
        bus_reqack = 1'b1;
        @(posedge clk);
        #1 bus_reqack = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (k == stop_beat) return;
            @(negedge clk);
            if (k == 0) chk("wait_reqcyc", 64'(bus_reqcyc), 64'd0);
            bus_respcyc = 1'b1;
            bus_resp = {seed + 32'(2 * k + 1), seed + 32'(2 * k)};
            flush = (k == flush_beat);
            #1 chk($sformatf("respack%0d", k), 64'(bus_respack), 64'd1);
            @(posedge clk);
            #1;
            bus_respcyc = 1'b0;
            flush = 1'b0;
        end
        @(negedge clk);
        chk("install_busidle", 64'(icache_busidle), 64'd0);
        chk("install_respack", 64'(bus_respack), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t hits [5];
        hits[0] = '{64'h1000, 1'b1, 32'h0};
        hits[1] = '{64'h1024, 1'b1, 32'h9};
        hits[2] = '{64'h103C, 1'b1, 32'hF};
        hits[3] = '{64'h1006, 1'b1, 32'h1};
        hits[4] = '{64'h1040, 1'b0, 32'h0};

        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_ack", 64'(data_ack), 64'd0);
        chk("rst_busreq", 64'(icache_busreq), 64'd0);
        chk("rst_busidle", 64'(icache_busidle), 64'd1);
        chk("rst_reqcyc", 64'(bus_reqcyc), 64'd0);
        chk("rst_respack", 64'(bus_respack), 64'd0);
        chk("rst_busreq_addr", bus_req, 64'd0);

        // Cold miss, then word-select hits
        run_miss(64'h1000, 32'h0, -1, 8);
        for (int i = 0; i < 5; i++) probe(hits[i]);

        // Unaligned miss: word 5 is the upper half of beat 2
        run_miss(64'h2014, 32'h100, -1, 8);
        probe('{64'h2014, 1'b1, 32'h105});
        probe('{64'h2000, 1'b1, 32'h100});
        probe('{64'h1000, 1'b1, 32'h0});

        // PLRU eviction in set 0x40
        run_miss(64'h9000, 32'h200, -1, 8);
        probe('{64'h9008, 1'b1, 32'h202});
        probe('{64'h1000, 1'b1, 32'h0});
        run_miss(64'h11000, 32'h300, -1, 8);
        probe('{64'h11004, 1'b1, 32'h301});
        probe('{64'h1000, 1'b1, 32'h0});
        probe('{64'h9000, 1'b0, 32'h0});

        // Flush in IDLE
        @(negedge clk);
        flush = 1'b1;
        pc = 64'h1000;
        pc_valid = 1'b1;
        #1 chk("flush_ack", 64'(data_ack), 64'd0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        pc_valid = 1'b0;
        probe('{64'h1000, 1'b0, 32'h0});
        probe('{64'h2000, 1'b0, 32'h0});

        // Flush pending during fill discards line and clears all
        run_miss(64'h2000, 32'h800, -1, 8);
        probe('{64'h2004, 1'b1, 32'h801});
        run_miss(64'h1000, 32'h700, 3, 8);
        probe('{64'h1000, 1'b0, 32'h0});
        probe('{64'h2004, 1'b0, 32'h0});

        // Reset after beat 3 of a fill
        run_miss(64'h1000, 32'h500, -1, 4);
        @(negedge clk);
        reset = 1'b1;
        bus_respcyc = 1'b1;
        bus_resp = 64'hDEAD_BEEF_DEAD_BEEF;
        pc = 64'h1000;
        pc_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("rstmid_busidle", 64'(icache_busidle), 64'd1);
        chk("rstmid_respack", 64'(bus_respack), 64'd0);
        chk("rstmid_ack", 64'(data_ack), 64'd0);
        chk("rstmid_busreq", 64'(icache_busreq), 64'd0);
        reset = 1'b0;
        bus_respcyc = 1'b0;
        pc_valid = 1'b0;
        @(posedge clk);
        #1;
        probe('{64'h1000, 1'b0, 32'h0});
        run_miss(64'h1000, 32'h600, -1, 8);
        probe('{64'h1000, 1'b1, 32'h600});
        probe('{64'h101C, 1'b1, 32'h607});

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/icache_nway.md
Name: icache_nway

Overview:
Parametrised N-way set-associative, read-only instruction cache between the fetch stage and the shared system bus.
- Replaces random replacement with tree-PLRU.
- Adds valid bits, a flush input, a latched miss address and a strict single-outstanding-miss FSM.
- Requests the bus through the arbiter handshake and fills whole lines with 64-bit burst beats.

Parameters:
WAYS, 2, associativity; power of 2, range 1..8
SETS, 512, sets per way; power of 2
LINE_BYTES, 64, line size; multiple of 8 (one bus beat)
BUS_DATA_WIDTH, 64, bus beat width; fixed at 64
BUS_TAG_WIDTH, 13, bus tag width

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
pc  in  64  fetch address; bits [1:0] ignored
pc_valid  in  1  fetch request this cycle
flush  in  1  invalidate all lines (one-cycle pulse)
instr_reg  out  32  fetched instruction
data_ack  out  1  instr_reg valid this cycle
icache_busreq  out  1  arbiter request
icache_busidle  out  1  cache not using bus
icache_busgrant  in  1  arbiter grant
bus_reqcyc  out  1  request valid
bus_req  out  64  line-aligned miss address
bus_reqtag  out  BUS_TAG_WIDTH  SYSBUS_READ<<8 | SYSBUS_MEMORY<<12
bus_reqack  in  1  request accepted
bus_respcyc  in  1  response beat valid
bus_resp  in  64  response beat
bus_resptag  in  BUS_TAG_WIDTH  response tag; not checked
bus_respack  out  1  beat accepted

Behaviour:
- Address split: OFF = log2(LINE_BYTES), IDX = log2(SETS), TAG = 64-IDX-OFF. Fields: offset pc[OFF-1:0], index pc[OFF+IDX-1:OFF], tag the rest.
- BEATS = LINE_BYTES/8.
- Lookup is combinational. Hit = state IDLE && pc_valid && any way with valid && tag match.
  - On hit: data_ack=1 the same cycle; instr_reg = 32-bit little-endian word at pc[OFF-1:2] of the hit line.
  - Otherwise data_ack=0 and instr_reg=0.
- PLRU update on a hit (registered at the clk edge) and on install.
- Reset values: state IDLE; all valid bits 0; PLRU bits 0; data_ack, busreq, reqcyc, respack = 0; busidle=1; bus_req=0; beat_cnt=0.
- FSM states: IDLE, ARB, REQ, WAIT, FILL, INSTALL.
  - IDLE: pc_valid && miss -> latch miss_addr = pc with offset zeroed -> ARB.
  - ARB: icache_busreq=1, busidle=0. icache_busgrant -> drive bus_req=miss_addr, reqtag, reqcyc=1 -> REQ.
  - REQ: hold reqcyc and bus_req until bus_reqack; then reqcyc=0 -> WAIT.
  - WAIT/FILL: each cycle with bus_respcyc:
    - store bus_resp at beat beat_cnt (bytes 8k..8k+7 of the line); assert bus_respack that cycle; beat_cnt++.
    - beats arrive ascending from the line base.
    - after beat BEATS-1 -> INSTALL.
  - INSTALL: write the line buffer into the victim way at miss_addr's index; set tag; valid=1; update PLRU -> IDLE.
- Miss penalty: the first hit to the filled line is the cycle after INSTALL.
- busidle=1 only in IDLE.
- Victim: lowest-numbered invalid way; if none, the tree-PLRU victim. WAYS=1 means always way 0.
- pc changes during a miss: ignored. The fill completes to miss_addr. The new pc is looked up on return to IDLE.
- flush in IDLE: all valid bits and PLRU cleared next edge; data_ack forced 0 that cycle.
- flush during ARB..FILL: recorded as pending; the bus transaction is not aborted. At INSTALL the line is discarded (not marked valid), then all valid bits are cleared.
- Reset mid-operation: immediate return to IDLE, reqcyc/respack/busreq deasserted. Bus-side cleanup is the system reset's job.
- Simultaneous flush and reset: reset wins (same result).
- Tag/data arrays are not reset; only the valid bits are.

Decomposition:
- Shared package icache_pkg:
  - state enum;
  - SYSBUS_READ / SYSBUS_MEMORY tag constants;
  - function computing the read-request tag.
- Sub-module plru_tree: per-set PLRU bit vector (WAYS-1 bits per set).
  - Inputs: access way and update enable.
  - Outputs: victim way.

Test Plan:
- Cold miss (defaults): pc=0x1000, pc_valid=1 -> busreq=1; grant -> bus_req=0x1000, reqtag=SYSBUS_READ<<8|SYSBUS_MEMORY<<12; ack; 8 beats 0x0..0x7 (beat k = {32'h(2k+1), 32'h(2k)}), respack each beat; data_ack=1, instr_reg=0x0 the cycle after INSTALL.
- Hit/word select: then pc=0x1024 -> data_ack same cycle, instr_reg=0x9; pc=0x103C -> 0xF. No bus activity.
- Unaligned miss: pc=0x2014 -> bus_req=0x2000; after fill instr_reg = upper half of beat 2.
- PLRU eviction (WAYS=2, same set via stride 0x8000): fill 0x1000, then 0x9000, hit 0x1000, miss 0x11000 -> 0x9000 evicted. Then 0x1000 hits; 0x9000 misses.
- Flush: after filling 0x1000, pulse flush in IDLE -> next lookup of 0x1000 misses. A flush pulse during FILL -> fill completes, 0x1000 still misses afterwards.
- Reset mid-fill: assert reset after beat 3 -> next cycle busidle=1, respack=0, data_ack=0; after release pc=0x1000 misses and refetches.
